quantum_watchdog: RTL and testbench

- Preemption timer for the Galetron multitasking OS.
- Counts user-mode instructions against an OS-programmed quantum. On expiry, waits for a safe instruction boundary, then raises a context-exchange request.
- Sits directly upstream of the CPU reset/context control logic, which consumes output_watchdog and context_exchange and gates the exchange jump with them.
- output_watchdog is non-zero exactly when preemption is armed; downstream logic ignores context_exchange when output_watchdog is 0.

---
 rtl/quantum_watchdog_if.sv | 26 ++
 rtl/quantum_watchdog.sv | 138 +++++++++++++
 tb/tb_quantum_watchdog.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/quantum_watchdog_if.sv
// Signal bundle between the retire stage / OS register port and the quantum watchdog.
// The master drives retire and quantum-write information; the slave returns preemption status.
interface quantum_watchdog_if #(
    parameter int PC_WIDTH      = 12,
    parameter int QUANTUM_WIDTH = 32
);
    logic [5:0]               operation;
    logic [PC_WIDTH-1:0]      program_counter;
    logic                     instruction_valid;
    logic                     quantum_write;
    logic [QUANTUM_WIDTH-1:0] quantum_data;
    logic [QUANTUM_WIDTH-1:0] output_watchdog;
    logic [QUANTUM_WIDTH-1:0] remaining;
    logic                     context_exchange;
    logic                     expired;

    modport master (
        output operation, program_counter, instruction_valid, quantum_write, quantum_data,
        input  output_watchdog, remaining, context_exchange, expired
    );

    modport slave (
        input  operation, program_counter, instruction_valid, quantum_write, quantum_data,
        output output_watchdog, remaining, context_exchange, expired
    );
endinterface

// File: rtl/quantum_watchdog.sv
// Preemption timer: counts user-mode instructions against an OS quantum and, once it is used up,
// requests a context exchange at the next safe instruction boundary.
module quantum_watchdog #(
    parameter int OS_BOUNDARY   = 256,
    parameter int PC_WIDTH      = 12,
    parameter int QUANTUM_WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    quantum_watchdog_if.slave bus
);
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        COUNTING = 2'd1,
        PENDING  = 2'd2,
        EXCHANGE = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0]      OS_BOUND_C   = PC_WIDTH'(OS_BOUNDARY);
    localparam logic [QUANTUM_WIDTH-1:0] Q_ZERO_C     = {QUANTUM_WIDTH{1'b0}};
    localparam logic [QUANTUM_WIDTH-1:0] Q_ONE_C      = {{(QUANTUM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [5:0]               OP_START_SYS = 6'b100111;

    // I/O and register-indirect memory ops are not a safe point to leave user code.
    function automatic logic is_safe_op(input logic [5:0] op);
        logic safe;
        case (op)
            6'b011101: safe = 1'b0;
            6'b100000: safe = 1'b0;
            6'b100001: safe = 1'b0;
            6'b100010: safe = 1'b0;
            default:   safe = 1'b1;
        endcase
        return safe;
    endfunction

    state_t                   state_r;
    state_t                   state_s;
    logic [QUANTUM_WIDTH-1:0] quantum_r;
    logic [QUANTUM_WIDTH-1:0] quantum_s;
    logic [QUANTUM_WIDTH-1:0] remaining_r;
    logic [QUANTUM_WIDTH-1:0] remaining_s;
    logic [QUANTUM_WIDTH-1:0] output_watchdog_r;
    logic                     context_exchange_r;
    logic                     expired_r;
    logic                     user_instr_s;
    logic                     os_instr_s;
    logic                     start_sys_s;

    assign user_instr_s = bus.instruction_valid && (bus.program_counter >= OS_BOUND_C);
    assign os_instr_s   = bus.instruction_valid && (bus.program_counter < OS_BOUND_C);
    assign start_sys_s  = bus.instruction_valid && (bus.operation == OP_START_SYS);

    // Next-state: quantum writes beat start_system, which beats normal sequencing.
    always_comb begin
        state_s     = state_r;
        quantum_s   = quantum_r;
        remaining_s = remaining_r;
        if (bus.quantum_write) begin
            if (bus.quantum_data != Q_ZERO_C) begin
                state_s     = COUNTING;
                quantum_s   = bus.quantum_data;
                remaining_s = bus.quantum_data;
            end else begin
                state_s     = DISARMED;
                quantum_s   = Q_ZERO_C;
                remaining_s = Q_ZERO_C;
            end
        end else if (start_sys_s) begin
            state_s     = DISARMED;
            quantum_s   = Q_ZERO_C;
            remaining_s = Q_ZERO_C;
        end else begin
            case (state_r)
                DISARMED: begin
                    state_s = DISARMED;
                end
                COUNTING: begin
                    if (user_instr_s) begin
                        if (remaining_r > Q_ONE_C) begin
                            remaining_s = remaining_r - Q_ONE_C;
                        end else begin
                            remaining_s = Q_ZERO_C;
                            state_s     = PENDING;
                        end
                    end else begin
                        state_s = COUNTING;
                    end
                end
                PENDING: begin
                    if (bus.instruction_valid && is_safe_op(bus.operation)) begin
                        state_s = EXCHANGE;
                    end else begin
                        state_s = PENDING;
                    end
                end
                EXCHANGE: begin
                    // OS has taken over: reload and pause until the user region resumes.
                    if (os_instr_s) begin
                        state_s     = COUNTING;
                        remaining_s = quantum_r;
                    end else begin
                        state_s = EXCHANGE;
                    end
                end
                default: begin
                    state_s     = DISARMED;
                    quantum_s   = Q_ZERO_C;
                    remaining_s = Q_ZERO_C;
                end
            endcase
        end
    end

    // State and registered outputs, all derived from the next-state values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r            <= DISARMED;
            quantum_r          <= Q_ZERO_C;
            remaining_r        <= Q_ZERO_C;
            output_watchdog_r  <= Q_ZERO_C;
            context_exchange_r <= 1'b0;
            expired_r          <= 1'b0;
        end else begin
            state_r            <= state_s;
            quantum_r          <= quantum_s;
            remaining_r        <= remaining_s;
            output_watchdog_r  <= (state_s != DISARMED) ? quantum_s : Q_ZERO_C;
            context_exchange_r <= (state_s == EXCHANGE);
            expired_r          <= (state_s == PENDING) || (state_s == EXCHANGE);
        end
    end

    assign bus.output_watchdog  = output_watchdog_r;
    assign bus.remaining        = remaining_r;
    assign bus.context_exchange = context_exchange_r;
    assign bus.expired          = expired_r;
endmodule

// File: tb/tb_quantum_watchdog.sv
// Directed bench for quantum_watchdog: each step drives one cycle of stimulus, queues the
// hand-derived outputs expected after that edge, and compares them once the edge has passed.
module tb_quantum_watchdog;
    localparam logic [5:0] OP_JUMP  = 6'b010101;
    localparam logic [5:0] OP_IN    = 6'b011101;
    localparam logic [5:0] OP_OUT   = 6'b100000;
    localparam logic [5:0] OP_LOADR = 6'b100001;
    localparam logic [5:0] OP_SSYS  = 6'b100111;

    typedef struct {
        string       tag;
        logic [31:0] ow;
        logic [31:0] rem;
        logic        cx;
        logic        ex;
    } exp_t;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    exp_t sb_q[$];

    quantum_watchdog_if #(.PC_WIDTH(12), .QUANTUM_WIDTH(32)) bus ();

    quantum_watchdog #(.OS_BOUNDARY(256), .PC_WIDTH(12), .QUANTUM_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_outputs();
        exp_t e;
        total = total + 1;
        assert (sb_q.size() > 0) else begin
            bad = bad + 1;
            $error("FAIL scoreboard empty got=%0d want=1", sb_q.size());
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total = total + 4;
            assert (bus.output_watchdog === e.ow) else begin
                bad = bad + 1;
                $error("FAIL %s output_watchdog got=%0d want=%0d", e.tag, bus.output_watchdog, e.ow);
            end
            assert (bus.remaining === e.rem) else begin
                bad = bad + 1;
                $error("FAIL %s remaining got=%0d want=%0d", e.tag, bus.remaining, e.rem);
            end
            assert (bus.context_exchange === e.cx) else begin
                bad = bad + 1;
                $error("FAIL %s context_exchange got=%0b want=%0b", e.tag, bus.context_exchange, e.cx);
            end
            assert (bus.expired === e.ex) else begin
                bad = bad + 1;
                $error("FAIL %s expired got=%0b want=%0b", e.tag, bus.expired, e.ex);
            end
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic v, input logic [5:0] op,
                        input logic [11:0] pc, input logic qw, input logic [31:0] qd,
                        input logic [31:0] e_ow, input logic [31:0] e_rem,
                        input logic e_cx, input logic e_ex);
        exp_t e;
        reset                 = rst;
        bus.instruction_valid = v;
        bus.operation         = op;
        bus.program_counter   = pc;
        bus.quantum_write     = qw;
        bus.quantum_data      = qd;
        e.tag = tag; e.ow = e_ow; e.rem = e_rem; e.cx = e_cx; e.ex = e_ex;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.instruction_valid = 1'b0;
        bus.operation         = 6'd0;
        bus.program_counter   = 12'd0;
        bus.quantum_write     = 1'b0;
        bus.quantum_data      = 32'd0;
        @(posedge clock);
        #1;

        step("reset0", 1'b0, 1'b0, OP_JUMP, 12'h000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("reset1", 1'b0, 1'b1, OP_JUMP, 12'h100, 1'b1, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step("idle", 1'b1, 1'b1, OP_JUMP, 12'h100 + 12'(i), 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // quantum 5 counted down by user instructions, then a safe op triggers the exchange
        step("wr5", 1'b1, 1'b1, OP_JUMP, 12'h100, 1'b1, 32'd5, 32'd5, 32'd5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step("cnt5", 1'b1, 1'b1, OP_JUMP, 12'h100 + 12'(i), 1'b0, 32'd0,
                 32'd5, 32'(4 - i), 1'b0, (i == 4) ? 1'b1 : 1'b0);
        step("safe5", 1'b1, 1'b1, OP_JUMP, 12'h105, 1'b0, 32'd0, 32'd5, 32'd0, 1'b1, 1'b1);
        step("osent5", 1'b1, 1'b1, OP_JUMP, 12'h010, 1'b0, 32'd0, 32'd5, 32'd5, 1'b0, 1'b0);

        // OS-region instructions and idle cycles never decrement
        step("wr3", 1'b1, 1'b0, OP_JUMP, 12'h020, 1'b1, 32'd3, 32'd3, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step("os3", 1'b1, 1'b1, OP_JUMP, 12'h020, 1'b0, 32'd0, 32'd3, 32'd3, 1'b0, 1'b0);
        step("nv3", 1'b1, 1'b0, OP_JUMP, 12'h200, 1'b0, 32'd0, 32'd3, 32'd3, 1'b0, 1'b0);
        step("pcff", 1'b1, 1'b1, OP_JUMP, 12'h0FF, 1'b0, 32'd0, 32'd3, 32'd3, 1'b0, 1'b0);

        // unsafe ops hold PENDING; only the jump raises the request
        step("wr2", 1'b1, 1'b0, OP_JUMP, 12'h100, 1'b1, 32'd2, 32'd2, 32'd2, 1'b0, 1'b0);
        step("c2a", 1'b1, 1'b1, OP_JUMP, 12'h100, 1'b0, 32'd0, 32'd2, 32'd1, 1'b0, 1'b0);
        step("c2b", 1'b1, 1'b1, OP_JUMP, 12'h101, 1'b0, 32'd0, 32'd2, 32'd0, 1'b0, 1'b1);
        step("op_in", 1'b1, 1'b1, OP_IN, 12'h102, 1'b0, 32'd0, 32'd2, 32'd0, 1'b0, 1'b1);
        step("op_out", 1'b1, 1'b1, OP_OUT, 12'h103, 1'b0, 32'd0, 32'd2, 32'd0, 1'b0, 1'b1);
        step("nv_pend", 1'b1, 1'b0, OP_JUMP, 12'h104, 1'b0, 32'd0, 32'd2, 32'd0, 1'b0, 1'b1);
        step("op_jmp", 1'b1, 1'b1, OP_JUMP, 12'h104, 1'b0, 32'd0, 32'd2, 32'd0, 1'b1, 1'b1);
        step("xhold", 1'b1, 1'b1, OP_LOADR, 12'h105, 1'b0, 32'd0, 32'd2, 32'd0, 1'b1, 1'b1);
        step("os_ret", 1'b1, 1'b1, OP_JUMP, 12'h010, 1'b0, 32'd0, 32'd2, 32'd2, 1'b0, 1'b0);
        step("c2c", 1'b1, 1'b1, OP_JUMP, 12'h100, 1'b0, 32'd0, 32'd2, 32'd1, 1'b0, 1'b0);
        step("c2d", 1'b1, 1'b1, OP_JUMP, 12'h101, 1'b0, 32'd0, 32'd2, 32'd0, 1'b0, 1'b1);
        step("x2", 1'b1, 1'b1, OP_JUMP, 12'h102, 1'b0, 32'd0, 32'd2, 32'd0, 1'b1, 1'b1);

        // disarm by writing zero in EXCHANGE, then by start_system while counting
        step("wr0x", 1'b1, 1'b1, OP_JUMP, 12'h103, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("wr4", 1'b1, 1'b0, OP_JUMP, 12'h100, 1'b1, 32'd4, 32'd4, 32'd4, 1'b0, 1'b0);
        step("c4", 1'b1, 1'b1, OP_JUMP, 12'h100, 1'b0, 32'd0, 32'd4, 32'd3, 1'b0, 1'b0);
        step("ssys", 1'b1, 1'b1, OP_SSYS, 12'h101, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("dis", 1'b1, 1'b1, OP_JUMP, 12'h102, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        // reset mid-count, then a quantum of 1 expires on the first user instruction
        step("wr7", 1'b1, 1'b0, OP_JUMP, 12'h100, 1'b1, 32'd7, 32'd7, 32'd7, 1'b0, 1'b0);
        step("rstmid", 1'b0, 1'b1, OP_JUMP, 12'h100, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step("wr1", 1'b1, 1'b0, OP_JUMP, 12'h100, 1'b1, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
        step("q1exp", 1'b1, 1'b1, OP_JUMP, 12'h100, 1'b0, 32'd0, 32'd1, 32'd0, 1'b0, 1'b1);

        // write coinciding with the expiring decrement wins; PC 0x100 is the first user address
        step("wr1b", 1'b1, 1'b0, OP_JUMP, 12'h100, 1'b1, 32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
        step("wrwin", 1'b1, 1'b1, OP_JUMP, 12'h100, 1'b1, 32'd9, 32'd9, 32'd9, 1'b0, 1'b0);
        step("bound", 1'b1, 1'b1, OP_JUMP, 12'h100, 1'b0, 32'd0, 32'd9, 32'd8, 1'b0, 1'b0);
        step("topad", 1'b1, 1'b1, OP_JUMP, 12'hFFF, 1'b0, 32'd0, 32'd9, 32'd7, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
